// File: rtl/ifetch_32_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings and the
// reset-time instruction constant.
package ifetch_32_pkg;

    // Fetch FSM states; encodings are fixed so other blocks and the bench can decode them.
    typedef enum logic [1:0] {
        ST_ADDR  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_t;

    // MIPS sll $0,$0,0: the canonical nop.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // True when a byte address is not word aligned.
    function automatic logic misaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_32_wait_timer.sv
// Up-counting wait timer: cleared by clr, advanced by en, flags the last
// permitted cycle (count == LIMIT-1). The owner leaves the wait state on
// expiry, so the count never wraps.
module wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // Counter register: synchronous active-low reset, clear has priority over count.
    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/ifetch_32.sv
// Instruction fetch stage: issues one word read per PC over a req/ack
// handshake, holds the fetched word until decode consumes it, and stalls the
// PC until then. Misaligned PCs and ack timeouts park the FSM in a sticky
// error state that only reset clears.
module ifetch_32
    import ifetch_32_pkg::*;
#(
    parameter int          TIMEOUT    = 15,
    parameter logic [31:0] RESET_INST = NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        consume,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        stall,
    output logic        fetch_err
);
    fetch_state_t state, state_nx;
    logic         tmr_clr, tmr_en, tmr_expired;

    // Counts REQ cycles without ack; cleared while sitting in ADDR.
    wait_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_ADDR;
        else
            state <= state_nx;
    end

    // Next-state and timer control. An ack on the last allowed cycle wins over the timeout.
    always_comb begin
        state_nx = state;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        case (state)
            ST_ADDR: begin
                tmr_clr  = 1'b1;
                state_nx = misaligned(pc_addr) ? ST_ERR : ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack)
                    state_nx = ST_VALID;
                else if (tmr_expired)
                    state_nx = ST_ERR;
                else
                    tmr_en = 1'b1;
            end
            ST_VALID: begin
                if (consume)
                    state_nx = ST_ADDR;
            end
            ST_ERR:  state_nx = ST_ERR;
            default: state_nx = ST_ADDR;
        endcase
    end

    // Datapath: latch the request address in ADDR and the read data on ack in REQ only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            imem_addr <= '0;
            inst      <= RESET_INST;
        end else begin
            if (state == ST_ADDR && !misaligned(pc_addr))
                imem_addr <= pc_addr;
            if (state == ST_REQ && imem_ack)
                inst <= imem_rdata;
        end
    end

    // Handshake and status outputs come from registered state; stall alone follows consume.
    assign imem_req   = (state == ST_REQ);
    assign inst_valid = (state == ST_VALID);
    assign fetch_err  = (state == ST_ERR);
    assign stall      = ~((state == ST_VALID) & consume);

endmodule
